// File: rtl/universal_shift_reg_negclk_negrst.sv
// WIDTH-bit universal shift register, falling-edge clocked, async active-low clear.
// Modes hold/right/left/load, optional end-around rotate, saturating shift counter.
module universal_shift_reg_negclk_negrst #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit              ROTATE      = 1'b0,
  parameter int              CNT_W       = $clog2(WIDTH+1)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic             SerInR,
  input  logic             SerInL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             SerOutR,
  output logic             SerOutL,
  output logic [CNT_W-1:0] ShiftCnt,
  output logic             Done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_r, in_l;

  // With ROTATE the bit falling off one end re-enters at the other.
  assign in_r = ROTATE ? q_q[0]       : SerInR;
  assign in_l = ROTATE ? q_q[WIDTH-1] : SerInL;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (En) begin
      unique case (Mode)
        2'b01: begin
          q_d = {in_r, q_q[WIDTH-1:1]};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
        2'b10: begin
          q_d = {q_q[WIDTH-2:0], in_l};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
        2'b11: begin
          q_d   = D;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge Clk or negedge Clr) begin
    if (!Clr) begin
      q_q   <= RESET_VALUE;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q        = q_q;
  assign Qbar     = ~q_q;
  assign SerOutR  = q_q[0];
  assign SerOutL  = q_q[WIDTH-1];
  assign ShiftCnt = cnt_q;
  assign Done     = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg_negclk_negrst.sv
// Bench for universal_shift_reg_negclk_negrst: plain and rotate instances share inputs.
module tb_universal_shift_reg_negclk_negrst;

  logic       Clk, Clr, En, SerInR, SerInL;
  logic [1:0] Mode;
  logic [7:0] D;
  logic [7:0] Q, Qbar, rQ, rQbar;
  logic       SerOutR, SerOutL, Done, rSerOutR, rSerOutL, rDone;
  logic [3:0] ShiftCnt, rShiftCnt;

  typedef struct {
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  universal_shift_reg_negclk_negrst #(.WIDTH(8), .RESET_VALUE(8'h00), .ROTATE(1'b0)) dut (
    .Clk(Clk), .Clr(Clr), .En(En), .Mode(Mode), .SerInR(SerInR), .SerInL(SerInL), .D(D),
    .Q(Q), .Qbar(Qbar), .SerOutR(SerOutR), .SerOutL(SerOutL), .ShiftCnt(ShiftCnt), .Done(Done)
  );

  universal_shift_reg_negclk_negrst #(.WIDTH(8), .RESET_VALUE(8'h00), .ROTATE(1'b1)) dut_rot (
    .Clk(Clk), .Clr(Clr), .En(En), .Mode(Mode), .SerInR(SerInR), .SerInL(SerInL), .D(D),
    .Q(rQ), .Qbar(rQbar), .SerOutR(rSerOutR), .SerOutL(rSerOutL), .ShiftCnt(rShiftCnt), .Done(rDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic en, input logic [1:0] mode, input logic sir,
                       input logic sil, input logic [7:0] d);
    En = en; Mode = mode; SerInR = sir; SerInL = sil; D = d;
  endtask

  task automatic tick;
    @(negedge Clk); #1;
  endtask

  task automatic test_reset;
    Clr = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    #1;
    tests++;
    if (Q !== 8'h00 || Qbar !== 8'hFF || ShiftCnt !== 4'd0 || Done !== 1'b0 ||
        rQ !== 8'h00 || rShiftCnt !== 4'd0) begin
      fails++;
      $display("FAIL reset: Q=%h Qbar=%h cnt=%0d done=%b rQ=%h, required Q=00 Qbar=FF cnt=0 done=0 rQ=00",
               Q, Qbar, ShiftCnt, Done, rQ);
    end
    #2 Clr = 1'b1;
  endtask

  task automatic test_load;
    @(negedge Clk); #1;
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
    sb.push_back('{q: 8'h3C, cnt: 4'd0, done: 1'b0});
    @(posedge Clk); #1;
    tests++;
    if (Q !== 8'h00) begin
      fails++;
      $display("FAIL load_rise: Q=%h after rising edge, required 00", Q);
    end
    @(negedge Clk); #1;
    e = sb.pop_front();
    tests++;
    if (Q !== e.q || Qbar !== ~e.q || ShiftCnt !== e.cnt || Done !== e.done) begin
      fails++;
      $display("FAIL load_fall: Q=%h Qbar=%h cnt=%0d done=%b, required Q=%h Qbar=%h cnt=%0d done=%b",
               Q, Qbar, ShiftCnt, Done, e.q, ~e.q, e.cnt, e.done);
    end
  endtask

  task automatic test_async_clr;
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    tick;
    @(posedge Clk); #2;
    Clr = 1'b0;
    #1;
    tests++;
    if (Q !== 8'h00 || ShiftCnt !== 4'd0 || Done !== 1'b0) begin
      fails++;
      $display("FAIL async_clr: Q=%h cnt=%0d done=%b, required Q=00 cnt=0 done=0", Q, ShiftCnt, Done);
    end
    Clr = 1'b1;
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF);
    sb.push_back('{q: 8'h00, cnt: 4'd0, done: 1'b0});
    tick;
    e = sb.pop_front();
    tests++;
    if (Q !== e.q || ShiftCnt !== e.cnt) begin
      fails++;
      $display("FAIL clr_release: Q=%h cnt=%0d, required Q=%h cnt=%0d", Q, ShiftCnt, e.q, e.cnt);
    end
  endtask

  task automatic test_shift_right;
    logic [7:0] seq;
    seq = 8'b1010_0101;
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
    tick;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
      tests++;
      if (SerOutR !== seq[i]) begin
        fails++;
        $display("FAIL serout_r[%0d]: got %b, required %b", i, SerOutR, seq[i]);
      end
      sb.push_back('{q: 8'hA5 >> (i + 1), cnt: 4'(i + 1), done: (i == 7)});
      tick;
      e = sb.pop_front();
      tests++;
      if (Q !== e.q || Qbar !== ~e.q || ShiftCnt !== e.cnt || Done !== e.done) begin
        fails++;
        $display("FAIL shift_right[%0d]: Q=%h cnt=%0d done=%b, required Q=%h cnt=%0d done=%b",
                 i, Q, ShiftCnt, Done, e.q, e.cnt, e.done);
      end
    end
  endtask

  task automatic test_saturation;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h80; exp_q[1] = 8'hC0; exp_q[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
      else       drive(1'b1, 2'b11, 1'b1, 1'b0, 8'h00);
      sb.push_back('{q: exp_q[i], cnt: (i < 2) ? 4'd8 : 4'd0, done: (i < 2)});
      tick;
      e = sb.pop_front();
      tests++;
      if (Q !== e.q || ShiftCnt !== e.cnt || Done !== e.done || SerOutL !== e.q[7]) begin
        fails++;
        $display("FAIL saturation[%0d]: Q=%h cnt=%0d done=%b serl=%b, required Q=%h cnt=%0d done=%b",
                 i, Q, ShiftCnt, Done, SerOutL, e.q, e.cnt, e.done);
      end
    end
  endtask

  task automatic test_rotate;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h03; exp_q[1] = 8'h81; exp_q[2] = 8'hC0;
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 0) ? 2'b10 : 2'b01, i[0], ~i[0], 8'h00);
      sb.push_back('{q: exp_q[i], cnt: 4'(i + 1), done: 1'b0});
      tick;
      e = sb.pop_front();
      tests++;
      if (rQ !== e.q || rQbar !== ~e.q || rShiftCnt !== e.cnt || rDone !== e.done) begin
        fails++;
        $display("FAIL rotate[%0d]: Q=%h cnt=%0d done=%b, required Q=%h cnt=%0d done=%b",
                 i, rQ, rShiftCnt, rDone, e.q, e.cnt, e.done);
      end
    end
  endtask

  task automatic test_hold;
    logic [1:0] modes [4];
    modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11; modes[3] = 2'b00;
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(i == 3, modes[i], 1'b1, 1'b1, 8'hFF);
      sb.push_back('{q: 8'h5A, cnt: 4'd0, done: 1'b0});
      tick;
      e = sb.pop_front();
      tests++;
      if (Q !== e.q || ShiftCnt !== e.cnt || Done !== e.done) begin
        fails++;
        $display("FAIL hold[%0d]: Q=%h cnt=%0d, required Q=%h cnt=%0d", i, Q, ShiftCnt, e.q, e.cnt);
      end
    end
  endtask

  // Left then right each count once; a disabled shift then must not touch the non-zero count.
  task automatic test_back_to_back;
    logic [7:0] exp_q [3];
    logic [3:0] exp_c [3];
    exp_q[0] = 8'hB5; exp_q[1] = 8'h5A; exp_q[2] = 8'h5A;
    exp_c[0] = 4'd1;  exp_c[1] = 4'd2;  exp_c[2] = 4'd2;
    for (int i = 0; i < 3; i++) begin
      drive(i != 2, (i == 0) ? 2'b10 : 2'b01, 1'b0, 1'b1, 8'h00);
      sb.push_back('{q: exp_q[i], cnt: exp_c[i], done: 1'b0});
      tick;
      e = sb.pop_front();
      tests++;
      if (Q !== e.q || ShiftCnt !== e.cnt || Done !== e.done) begin
        fails++;
        $display("FAIL back_to_back[%0d]: Q=%h cnt=%0d done=%b, required Q=%h cnt=%0d done=%b",
                 i, Q, ShiftCnt, Done, e.q, e.cnt, e.done);
      end
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_async_clr;
    test_shift_right;
    test_saturation;
    test_rotate;
    test_hold;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
